census_hamming_serializer: RTL and testbench

//  Upstream feeder of the Hamming-cost normalisation stage in the disparity-map path.

---
 rtl/census_hamming_serializer_if.sv | 44 ++++
 rtl/census_hamming_serializer.sv | 160 ++++++++++++++++
 tb/tb_census_hamming_serializer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/census_hamming_serializer_if.sv
// -----------------------------------------------------------------------------
// census_hamming_serializer_if
// Purpose : bundles the pixel-in and cost-out streams of the census Hamming
//           serializer so the block and its neighbours share one port.
// Signals :
//   pix_valid / pix_ready   pixel handshake (master -> block)
//   line_start              pixel is column 0 of a new row
//   census_l / census_r     left / right census codes of the same column
//   cost_valid              cost_hamming / cost_disp / cost_last are valid
//   cost_hamming            Hamming cost 0..CENSUS_W
//   cost_disp               disparity of the cost
//   cost_last               last cost of the pixel (d = MAX_DISP-1)
//
// Handshake: a pixel transfers on a rising clk edge where pix_valid,
// pix_ready and clken are all high. The master keeps pix_valid and its data
// stable until that edge; pix_ready never depends on pix_valid. The cost
// stream has no back-pressure: the consumer takes each cost on every edge
// where cost_valid and clken are high.
// -----------------------------------------------------------------------------
interface census_hamming_serializer_if #(
  parameter int CENSUS_W = 9,
  parameter int DISP_W   = 4,
  parameter int COST_W   = 4
);
  logic                pix_valid;
  logic                pix_ready;
  logic                line_start;
  logic [CENSUS_W-1:0] census_l;
  logic [CENSUS_W-1:0] census_r;
  logic                cost_valid;
  logic [COST_W-1:0]   cost_hamming;
  logic [DISP_W-1:0]   cost_disp;
  logic                cost_last;

  modport master (
    output pix_valid, line_start, census_l, census_r,
    input  pix_ready, cost_valid, cost_hamming, cost_disp, cost_last
  );

  modport slave (
    input  pix_valid, line_start, census_l, census_r,
    output pix_ready, cost_valid, cost_hamming, cost_disp, cost_last
  );
endinterface

// File: rtl/census_hamming_serializer.sv
// -----------------------------------------------------------------------------
// census_hamming_serializer
// Purpose : keeps a MAX_DISP-deep history of right census codes for the
//           current row and, for every accepted left pixel, emits one Hamming
//           cost per cycle for d = 0..MAX_DISP-1 in ascending order.
// Ports   :
//   clk          system clock, rising edge
//   rst          asynchronous reset, active-high
//   clken        global stall; low freezes every flop
//   bus          census_hamming_serializer_if.slave (pixel in, cost out)
//   o_dbg_state  current FSM state (0 = IDLE, 1 = SWEEP)
// -----------------------------------------------------------------------------
module census_hamming_serializer #(
  parameter int CENSUS_W = 9,
  parameter int MAX_DISP = 16,
  parameter int DISP_W   = 4,
  parameter int COST_W   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clken,
  census_hamming_serializer_if.slave bus,
  output logic o_dbg_state
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  localparam logic [DISP_W-1:0] D_LAST    = DISP_W'(MAX_DISP - 1);
  localparam logic [COST_W-1:0] COST_MASK = COST_W'(CENSUS_W);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DISP_W-1:0]   r_d;
  logic [DISP_W-1:0]   w_d_nxt;
  logic [DISP_W-1:0]   r_col;
  logic [DISP_W-1:0]   w_col_nxt;
  // Set by reset: the first pixel afterwards is column 0 even without line_start.
  logic                r_first;
  logic [CENSUS_W-1:0] r_hist [MAX_DISP];
  logic [CENSUS_W-1:0] r_census_l;

  logic                w_pix_ready;
  logic                w_accept;
  logic                w_sweep;
  logic [CENSUS_W-1:0] w_xor;
  logic [COST_W-1:0]   w_pop;
  logic [COST_W-1:0]   w_cost;

  // Ready in IDLE, or on the last disparity so the next pixel follows with no gap.
  assign w_pix_ready   = (r_state == ST_IDLE) || (r_d == D_LAST);
  assign w_accept      = bus.pix_valid & w_pix_ready & clken;
  assign bus.pix_ready = w_pix_ready;
  assign o_dbg_state   = r_state;

  // Next-state / sweep control
  always_comb begin
    w_state_nxt = r_state;
    w_d_nxt     = r_d;
    w_sweep     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_SWEEP;
          w_d_nxt     = '0;
        end
      end
      ST_SWEEP: begin
        w_sweep = 1'b1;
        if (w_accept) begin
          w_d_nxt = '0;
        end else if (r_d == D_LAST) begin
          w_state_nxt = ST_IDLE;
          w_d_nxt     = '0;
        end else begin
          w_d_nxt = r_d + DISP_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_d_nxt     = '0;
      end
    endcase
  end

  // Column of the incoming pixel, saturating once the history is full.
  always_comb begin
    w_col_nxt = r_col;
    if (bus.line_start || r_first) begin
      w_col_nxt = '0;
    end else if (r_col != D_LAST) begin
      w_col_nxt = r_col + DISP_W'(1);
    end
  end

  // Cost for the current disparity; columns left of the row start are masked
  // to the worst cost so history from a previous row is never used.
  always_comb begin
    w_xor = r_census_l ^ r_hist[r_d];
    w_pop = '0;
    for (int i = 0; i < CENSUS_W; i++) begin
      w_pop = w_pop + COST_W'(w_xor[i]);
    end
    w_cost = (r_d > r_col) ? COST_MASK : w_pop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_d     <= '0;
    end else if (clken) begin
      r_state <= w_state_nxt;
      r_d     <= w_d_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col      <= '0;
      r_first    <= 1'b1;
      r_census_l <= '0;
      for (int k = 0; k < MAX_DISP; k++) begin
        r_hist[k] <= '0;
      end
    end else if (w_accept) begin
      r_col      <= w_col_nxt;
      r_first    <= 1'b0;
      r_census_l <= bus.census_l;
      r_hist[0]  <= bus.census_r;
      for (int k = 1; k < MAX_DISP; k++) begin
        r_hist[k] <= r_hist[k-1];
      end
    end
  end

  // Output register: one cost per sweep cycle, cleared when not sweeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.cost_valid   <= 1'b0;
      bus.cost_hamming <= '0;
      bus.cost_disp    <= '0;
      bus.cost_last    <= 1'b0;
    end else if (clken) begin
      if (w_sweep) begin
        bus.cost_valid   <= 1'b1;
        bus.cost_hamming <= w_cost;
        bus.cost_disp    <= r_d;
        bus.cost_last    <= (r_d == D_LAST);
      end else begin
        bus.cost_valid   <= 1'b0;
        bus.cost_hamming <= '0;
        bus.cost_disp    <= '0;
        bus.cost_last    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_census_hamming_serializer.sv
module tb_census_hamming_serializer;

  logic clk;
  logic rst;
  logic clken;
  logic dbg_state;

  census_hamming_serializer_if bus_if ();

  census_hamming_serializer dut (
    .clk         (clk),
    .rst         (rst),
    .clken       (clken),
    .bus         (bus_if.slave),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard ----------------
  // entry = {cost_last, cost_disp[3:0], cost_hamming[3:0]}
  logic [8:0] exp_q[$];
  int         acc_cyc[$];
  bit         sb_en    = 1'b1;
  int         run_len  = 0;
  int         last_run = 0;

  always @(posedge clk) begin
    logic       en_edge;
    logic [8:0] got;
    logic [8:0] e;
    en_edge = clken;
    #1;
    if (en_edge && !rst) begin
      if (bus_if.cost_valid === 1'b1) begin
        run_len++;
        if (sb_en) begin
          got = {bus_if.cost_last, bus_if.cost_disp, bus_if.cost_hamming};
          n_total++;
          if (exp_q.size() == 0) begin
            $display("FAIL sb_unexpected got=%h required=none", got);
          end else begin
            e = exp_q.pop_front();
            if (got !== e)
              $display("FAIL sb_cost got last/disp/cost=%b/%0d/%0d required=%b/%0d/%0d",
                       got[8], got[7:4], got[3:0], e[8], e[7:4], e[3:0]);
            else
              n_pass++;
          end
        end
      end else begin
        if (run_len != 0) last_run = run_len;
        run_len = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(input int d, input int c);
    logic [3:0] dd;
    logic [3:0] cc;
    dd = 4'(d);
    cc = 4'(c);
    exp_q.push_back({(d == 15), dd, cc});
  endtask

  // Called just after a negedge; returns at the negedge after the accept edge.
  task automatic send_pixel(input logic ls, input logic [8:0] l, input logic [8:0] r);
    int guard;
    guard = 0;
    bus_if.pix_valid  = 1'b1;
    bus_if.line_start = ls;
    bus_if.census_l   = l;
    bus_if.census_r   = r;
    while (!(bus_if.pix_ready === 1'b1 && clken === 1'b1)) begin
      @(negedge clk);
      guard++;
      if (guard > 100) begin
        n_total++;
        $display("FAIL accept_timeout got=no_ready required=ready");
        break;
      end
    end
    acc_cyc.push_back(cyc);
    @(negedge clk);
    bus_if.pix_valid  = 1'b0;
    bus_if.line_start = 1'b0;
  endtask

  task automatic drain(output bit ok);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 400) begin
      @(negedge clk);
      g++;
    end
    repeat (3) @(negedge clk);
    ok = (exp_q.size() == 0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    bit ok;
    repeat (3) @(negedge clk);
    n_total++; if (bus_if.cost_valid !== 1'b0) $display("FAIL rst_valid got=%b required=0", bus_if.cost_valid); else n_pass++;
    n_total++; if (bus_if.cost_hamming !== 4'd0) $display("FAIL rst_cost got=%0d required=0", bus_if.cost_hamming); else n_pass++;
    n_total++; if (bus_if.cost_disp !== 4'd0) $display("FAIL rst_disp got=%0d required=0", bus_if.cost_disp); else n_pass++;
    n_total++; if (bus_if.cost_last !== 1'b0) $display("FAIL rst_last got=%b required=0", bus_if.cost_last); else n_pass++;
    n_total++; if (bus_if.pix_ready !== 1'b1) $display("FAIL rst_ready got=%b required=1", bus_if.pix_ready); else n_pass++;
    n_total++; if (dbg_state !== 1'b0) $display("FAIL rst_state got=%b required=0", dbg_state); else n_pass++;
    rst = 1'b0;
    @(negedge clk);

    // abort a sweep at d=7
    sb_en = 1'b0;
    send_pixel(1'b1, 9'h1A5, 9'h1A5);
    repeat (7) @(negedge clk);
    n_total++; if (bus_if.pix_ready !== 1'b0) $display("FAIL mid_ready got=%b required=0", bus_if.pix_ready); else n_pass++;
    n_total++; if (bus_if.cost_disp !== 4'd6) $display("FAIL mid_disp got=%0d required=6", bus_if.cost_disp); else n_pass++;
    rst = 1'b1;
    #1;
    n_total++; if (bus_if.cost_valid !== 1'b0) $display("FAIL abort_valid got=%b required=0", bus_if.cost_valid); else n_pass++;
    n_total++; if (bus_if.cost_hamming !== 4'd0) $display("FAIL abort_cost got=%0d required=0", bus_if.cost_hamming); else n_pass++;
    n_total++; if (bus_if.pix_ready !== 1'b1) $display("FAIL abort_ready got=%b required=1", bus_if.pix_ready); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    sb_en = 1'b1;

    // without line_start, first pixel after reset is column 0
    push_exp(0, 1);
    for (int d = 1; d < 16; d++) push_exp(d, 9);
    send_pixel(1'b0, 9'h1A5, 9'h1A4);
    drain(ok);
    n_total++; if (!ok) $display("FAIL drain_reset got=%0d left required=0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_match_row;
    bit ok;
    for (int col = 0; col < 20; col++) begin
      for (int d = 0; d < 16; d++) push_exp(d, (col >= 15 || d <= col) ? 0 : 9);
      send_pixel(col == 0, 9'h1A5, 9'h1A5);
    end
    drain(ok);
    n_total++; if (!ok) $display("FAIL drain_match got=%0d left required=0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_left_edge;
    bit ok;
    push_exp(0, 1);
    for (int d = 1; d < 16; d++) push_exp(d, 9);
    send_pixel(1'b1, 9'h1A5, 9'h1A4);
    push_exp(0, 0);
    push_exp(1, 1);
    for (int d = 2; d < 16; d++) push_exp(d, 9);
    send_pixel(1'b0, 9'h1A5, 9'h1A5);
    drain(ok);
    n_total++; if (!ok) $display("FAIL drain_edge got=%0d left required=0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_real_match;
    bit ok;
    push_exp(0, 0);
    for (int d = 1; d < 16; d++) push_exp(d, 9);
    send_pixel(1'b1, 9'h000, 9'h000);
    for (int col = 1; col <= 5; col++) begin
      for (int d = 0; d < 16; d++) push_exp(d, (d < col) ? 0 : 9);
      send_pixel(1'b0, 9'h1FF, 9'h1FF);
    end
    drain(ok);
    n_total++; if (!ok) $display("FAIL drain_real got=%0d left required=0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_back_to_back;
    bit ok;
    acc_cyc.delete();
    last_run = 0;
    for (int col = 0; col < 4; col++) begin
      for (int d = 0; d < 16; d++) push_exp(d, (d <= col) ? 0 : 9);
    end
    for (int col = 0; col < 4; col++) send_pixel(col == 0, 9'h0F0, 9'h0F0);
    drain(ok);
    n_total++; if (!ok) $display("FAIL drain_b2b got=%0d left required=0", exp_q.size()); else n_pass++;
    for (int i = 1; i < 4; i++) begin
      n_total++;
      if (acc_cyc[i] - acc_cyc[i-1] !== 16)
        $display("FAIL b2b_spacing got=%0d required=16", acc_cyc[i] - acc_cyc[i-1]);
      else n_pass++;
    end
    n_total++; if (last_run !== 64) $display("FAIL b2b_run got=%0d required=64", last_run); else n_pass++;
  endtask

  task automatic test_clken_stall;
    bit ok;
    push_exp(0, 0);
    for (int d = 1; d < 16; d++) push_exp(d, 9);
    send_pixel(1'b1, 9'h1A5, 9'h1A5);
    repeat (8) @(negedge clk);
    clken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++; if (bus_if.cost_valid !== 1'b1) $display("FAIL stall_valid got=%b required=1", bus_if.cost_valid); else n_pass++;
      n_total++; if (bus_if.cost_disp !== 4'd7) $display("FAIL stall_disp got=%0d required=7", bus_if.cost_disp); else n_pass++;
      n_total++; if (bus_if.cost_hamming !== 4'd9) $display("FAIL stall_cost got=%0d required=9", bus_if.cost_hamming); else n_pass++;
      n_total++; if (dbg_state !== 1'b1) $display("FAIL stall_state got=%b required=1", dbg_state); else n_pass++;
    end
    clken = 1'b1;
    drain(ok);
    n_total++; if (!ok) $display("FAIL drain_stall got=%0d left required=0", exp_q.size()); else n_pass++;
  endtask

  initial begin
    rst               = 1'b1;
    clken             = 1'b1;
    bus_if.pix_valid  = 1'b0;
    bus_if.line_start = 1'b0;
    bus_if.census_l   = '0;
    bus_if.census_r   = '0;
    test_reset();
    test_match_row();
    test_left_edge();
    test_real_match();
    test_back_to_back();
    test_clken_stall();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
